// File: rtl/aes_128_inv_pkg.sv
// Shared constants and GF(2^8) helpers for the iterative AES-128 inverse cipher.
// S-box values are computed arithmetically (field inverse plus affine map).
package aes_inv_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] KEYEXP = 2'd1;
    localparam logic [1:0] DEC    = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

endpackage

// File: rtl/aes_128_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_inv_pkg::*;
(
    input  logic [127:0] s,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] out
);

    logic [127:0] sub;
    logic [127:0] added;
    logic [127:0] mixed;

    always_comb begin
        sub   = '0;
        mixed = '0;
        // Byte (row r, column c) lives at index 4*c+r; row r rotates right by r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub[127 - 8*(4*c + r) -: 8] = sbox_inv(s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
            end
        end
        added = sub ^ rk;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = inv_mix_col(added[127 - 32*c -: 32]);
        end
        out = last ? added : mixed;
    end

endmodule

// File: rtl/aes_128_inv_sbox.sv
// Forward AES S-box, one byte in, one byte out; used by the key schedule.
module aes_sbox
    import aes_inv_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_fwd(in_byte);

endmodule

// File: rtl/aes_128_inv.sv
// Iterative AES-128 decryption: expands the key forward to round 10, then
// unwinds the schedule one round per clock while decrypting.
module aes_128_inv
    import aes_inv_pkg::*;
#(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds valid and data stable until that edge.
    logic [1:0]   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_q, key_d;
    logic [127:0] k_q, k_d;
    logic [127:0] s_q, s_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] cached_key_q, cached_key_d;
    logic [127:0] cached_rk10_q, cached_rk10_d;
    logic         cache_valid_q, cache_valid_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sb_in, rot_w, sub_w, rc_w;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] fwd_k, inv_k, round_out;

    assign {w0, w1, w2, w3} = k_q;

    // The same four S-boxes serve both directions: w3 going forward, w3^w2 going back.
    assign sb_in = (state_q == DEC) ? (w3 ^ w2) : w3;
    assign rot_w = {sb_in[23:0], sb_in[31:24]};
    assign rc_w  = {rcon((state_q == DEC) ? (rnd_q + 4'd1) : rnd_q), 24'h000000};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte (rot_w[31 - 8*b -: 8]),
            .out_byte(sub_w[31 - 8*b -: 8])
        );
    end

    assign f0    = w0 ^ sub_w ^ rc_w;
    assign f1    = w1 ^ f0;
    assign f2    = w2 ^ f1;
    assign f3    = w3 ^ f2;
    assign fwd_k = {f0, f1, f2, f3};
    assign inv_k = {w0 ^ sub_w ^ rc_w, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    aes_inv_round u_round (
        .s   (s_q),
        .rk  (inv_k),
        .last(rnd_q == 4'd0),
        .out (round_out)
    );

    always_comb begin
        state_d       = state_q;
        rnd_d         = rnd_q;
        ct_d          = ct_q;
        key_d         = key_q;
        k_d           = k_q;
        s_d           = s_q;
        pt_d          = pt_q;
        cached_key_d  = cached_key_q;
        cached_rk10_d = cached_rk10_q;
        cache_valid_d = cache_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ct_d  = ct;
                    key_d = key;
                    if (KEY_CACHE && cache_valid_q && (key == cached_key_q)) begin
                        k_d     = cached_rk10_q;
                        s_d     = ct ^ cached_rk10_q;
                        rnd_d   = 4'd9;
                        state_d = DEC;
                    end else begin
                        k_d     = key;
                        rnd_d   = 4'd1;
                        state_d = KEYEXP;
                    end
                end
            end
            KEYEXP: begin
                k_d = fwd_k;
                if (rnd_q == 4'd10) begin
                    s_d           = ct_q ^ fwd_k;
                    cached_key_d  = key_q;
                    cached_rk10_d = fwd_k;
                    cache_valid_d = 1'b1;
                    rnd_d         = 4'd9;
                    state_d       = DEC;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DEC: begin
                k_d = inv_k;
                s_d = round_out;
                if (rnd_q == 4'd0) begin
                    pt_d    = round_out;
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            default: begin
                if (out_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rnd_q         <= '0;
            ct_q          <= '0;
            key_q         <= '0;
            k_q           <= '0;
            s_q           <= '0;
            pt_q          <= '0;
            cached_key_q  <= '0;
            cached_rk10_q <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rnd_q         <= rnd_d;
            ct_q          <= ct_d;
            key_q         <= key_d;
            k_q           <= k_d;
            s_q           <= s_d;
            pt_q          <= pt_d;
            cached_key_q  <= cached_key_d;
            cached_rk10_q <= cached_rk10_d;
            cache_valid_q <= cache_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign pt        = pt_q;

endmodule

// File: doc/aes_128_inv.md
Name: aes_128_inv

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 decryption). It is the receive-side counterpart to the existing aes_128 encryption core.
- Accepts a 128-bit ciphertext and cipher key over a valid/ready handshake and returns plaintext over a second valid/ready handshake.
- Computes one round per clock. It expands the key forward, then walks the schedule backward on the fly, so the round-key array is never stored.
- Sits beside aes_128 in the crypto subsystem for round-trip self-check and decrypt paths.

Parameters:
- KEY_CACHE, 1, when 1 the last expanded round-10 key is retained and the expansion phase is skipped if the next key is identical; when 0 every block re-expands.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  ct/key presented
- in_ready  output  1  block can accept a request
- ct  input  128  ciphertext; bits 127:120 = byte 0 (FIPS order, column-major)
- key  input  128  cipher key (round key 0), same byte order
- out_valid  output  1  pt valid
- out_ready  input  1  consumer accepts pt
- pt  output  128  plaintext, same byte order
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Port names are clk and rst.
- Reset values: in_ready=1, out_valid=0, pt=0, busy=0, state=IDLE, cache_valid=0, round counter=0.
- FSM states: IDLE, KEYEXP, DEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch ct and key.
  - If KEY_CACHE=1, cache_valid=1 and key equals cached_key: load k<=cached_rk10 and s<=ct^cached_rk10, then go to DEC.
  - Otherwise load k<=key, set i=1, and go to KEYEXP.
- KEYEXP:
  - 10 cycles, i=1..10.
  - Each cycle: k<=forward_schedule(k, rcon[i]), using SubWord(RotWord(w3)) with the forward S-box.
  - On i=10 also set s<=ct_reg^next_k, store cached_key<=key_reg and cached_rk10<=next_k, set cache_valid<=1, set r=9, and go to DEC.
- DEC:
  - 10 cycles, r=9..0.
  - Each cycle: rk_r = inverse_schedule(k, rcon[r+1]), where w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, and w0'=w0^SubWord(RotWord(w3'))^rcon. Then k<=rk_r.
  - For r>=1: s<=InvMixColumns(InvSubBytes(InvShiftRows(s))^rk_r).
  - For r=0: s<=InvSubBytes(InvShiftRows(s))^rk0, with no InvMixColumns. Then pt<=that value and go to DONE.
- DONE:
  - out_valid=1. pt is held stable until out_ready.
  - On out_ready: out_valid<=0 and go to IDLE.
  - in_ready=0 throughout DONE; there is no overlap of consecutive blocks.
- Latency, accept edge to out_valid high:
  - 20 cycles on a cache miss or when KEY_CACHE=0.
  - 10 cycles on a cache hit.
- Throughput: 1 block per latency+2 cycles minimum, given out_ready held high.
- in_valid in non-IDLE states is ignored. The request must be held by the producer per standard valid/ready rules.
- Input changes on ct/key after acceptance have no effect on the block in flight.
- Reset mid-operation: immediate abort, all outputs return to reset values, and cache_valid is cleared.
- All arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns uses the coefficients 0e,0b,0d,09.

Decomposition:
- Package aes_inv_pkg holds:
  - state enum {IDLE,KEYEXP,DEC,DONE}
  - rcon[1..10] constants {01,02,04,08,10,20,40,80,1b,36}
  - GF xtime/multiply functions and the InvMixColumns column function
- Sub-module aes_inv_round, purely combinational:
  - Inputs s, rk, last.
  - Output: InvShiftRows, then InvSubBytes (16 inverse S-box lookups), then AddRoundKey, then InvMixColumns when !last.
- Key schedule uses 4 instances of the team's existing forward S-box.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff; out_valid exactly 20 cycles after accept; internal k after KEYEXP = 13111d7fe3944a17f307a78b4d2b30c5.
- Cache hit: repeat C.1 with the same key back-to-back -> same pt, out_valid 10 cycles after accept. Repeat with KEY_CACHE=0 -> 20 cycles.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734. The key change forces a 20-cycle miss.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid -> pt stable, in_ready=0, and a new in_valid is not accepted until one cycle after out_ready handshake.
- Reset mid-DEC: assert rst at DEC r=4 -> out_valid=0, in_ready=1, busy=0 immediately. Re-run C.1 -> 20-cycle latency because the cache is cleared, and pt is correct.
- Round trip: 200 random key/pt pairs through aes_128 then aes_128_inv -> pt recovered bit-exact, with random out_ready stalls.
